// File: rtl/aes_pkg.sv
// Shared types and constants for the AES job scheduler: block width, channel
// indices and the scheduler state encoding.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int NUM_REQ   = 2;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  function automatic logic [NUM_REQ-1:0] ch_onehot(input logic ch);
    return (ch == CH1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and on a tie the
// channel that was not granted last time wins.
module aes_rr_arb2
  import aes_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_grant_i == CH1) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one start/done AES-128 core between two requesters: round-robin job
// accept, single-cycle issue, bounded wait for done, response to the owner.
module aes_job_scheduler
  import aes_pkg::*;
#(
  parameter int BLK_W          = AES_BLK_W,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*BLK_W-1:0] req_key,
  input  logic [2*BLK_W-1:0] req_data,
  input  logic [1:0]         req_decrypt,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [BLK_W-1:0]   resp_data,
  output logic               resp_err,
  output logic               core_start,
  output logic               core_decrypt,
  output logic [BLK_W-1:0]   core_key,
  output logic [BLK_W-1:0]   core_data,
  input  logic               core_done,
  input  logic [BLK_W-1:0]   core_result,
  output logic               busy,
  output logic [7:0]         err_count
);

  sched_state_e     state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic             dec_q, dec_d;
  logic [BLK_W-1:0] rdata_q, rdata_d;
  logic             rerr_q, rerr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       errcnt_q, errcnt_d;
  logic [1:0]       gnt;

  aes_rr_arb2 u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  // Ready is a pure decode of the grant so a job can be taken the same cycle it appears.
  assign req_ready    = (state_q == S_IDLE && !rst) ? gnt : 2'b00;
  assign resp_data    = rdata_q;
  assign resp_err     = rerr_q;
  assign core_key     = key_q;
  assign core_data    = data_q;
  assign core_decrypt = dec_q;
  assign busy         = (state_q != S_IDLE);
  assign err_count    = errcnt_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    key_d        = key_q;
    data_d       = data_q;
    dec_d        = dec_q;
    rdata_d      = rdata_q;
    rerr_d       = rerr_q;
    cnt_d        = cnt_q;
    errcnt_d     = errcnt_q;
    resp_valid   = 2'b00;
    core_start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = gnt[CH1];
          key_d   = gnt[CH1] ? req_key[2*BLK_W-1:BLK_W]  : req_key[BLK_W-1:0];
          data_d  = gnt[CH1] ? req_data[2*BLK_W-1:BLK_W] : req_data[BLK_W-1:0];
          dec_d   = gnt[CH1] ? req_decrypt[1]            : req_decrypt[0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_start = 1'b1;
        cnt_d      = '0;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done arriving on the last allowed cycle still counts as success.
        if (core_done) begin
          rdata_d = core_result;
          rerr_d  = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          if (errcnt_q != 8'hFF) begin
            errcnt_d = errcnt_q + 8'd1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = ch_onehot(owner_q);
        if (resp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= CH0;
      last_grant_q <= CH1;
      key_q        <= '0;
      data_q       <= '0;
      dec_q        <= 1'b0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
      cnt_q        <= '0;
      errcnt_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      key_q        <= key_d;
      data_q       <= data_d;
      dec_q        <= dec_d;
      rdata_q      <= rdata_d;
      rerr_q       <= rerr_d;
      cnt_q        <= cnt_d;
      errcnt_q     <= errcnt_d;
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Self-checking bench for aes_job_scheduler with a behavioural AES core stand-in
// and a small arbitration/error-count reference model.
`timescale 1ns/1ps
module tb_aes_job_scheduler;
  localparam int W = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready, req_decrypt;
  logic [2*W-1:0] req_key, req_data;
  logic [1:0]     resp_valid, resp_ready;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           core_start, core_decrypt, core_done, busy;
  logic [W-1:0]   core_key, core_data, core_result;
  logic [7:0]     err_count;

  int checks = 0;
  int errors = 0;

  int           coreLat = 0;
  int           coreWait = 0;
  bit           corePend = 0;
  int           coreStarts = 0;
  bit           injectDone = 0;
  logic [W-1:0] injectVal = '0;
  bit           useFixed = 0;
  logic [W-1:0] fixedResult = '0;
  logic [W-1:0] cKey, cData;
  logic         cDec;

  logic [W-1:0] jobKey [2];
  logic [W-1:0] jobData [2];
  logic         jobDec [2];
  logic         tbLastGrant = 1'b1;
  int           tbErrCnt = 0;

  aes_job_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .req_data     (req_data),
    .req_decrypt  (req_decrypt),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .core_start   (core_start),
    .core_decrypt (core_decrypt),
    .core_key     (core_key),
    .core_data    (core_data),
    .core_done    (core_done),
    .core_result  (core_result),
    .busy         (busy),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] coreFn(input logic [W-1:0] k, input logic [W-1:0] d, input logic m);
    return d ^ {k[63:0], k[127:64]} ^ {W{m}};
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [1:0] onehot(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

  // Core stand-in: answers coreLat cycles after a start (coreLat <= 0 means never).
  initial begin
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (injectDone) begin
        core_done = 1'b1;
        core_result = injectVal;
        injectDone = 0;
      end else if (corePend) begin
        coreWait--;
        if (coreWait == 0) begin
          corePend = 0;
          core_done = 1'b1;
          core_result = useFixed ? fixedResult : coreFn(cKey, cData, cDec);
        end
      end
      if (core_start === 1'b1) begin
        coreStarts++;
        cKey = core_key;
        cData = core_data;
        cDec = core_decrypt;
        if (coreLat > 0) begin
          corePend = 1;
          coreWait = coreLat;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic waitResp(input int maxC, output int n);
    n = 0;
    while (resp_valid == 2'b00 && n < maxC) begin
      step();
      n++;
    end
  endtask

  task automatic setJob(input logic ch, input logic [W-1:0] k, input logic [W-1:0] d, input logic m);
    jobKey[ch] = k;
    jobData[ch] = d;
    jobDec[ch] = m;
    if (ch) begin
      req_key[2*W-1:W] = k;
      req_data[2*W-1:W] = d;
      req_decrypt[1] = m;
    end else begin
      req_key[W-1:0] = k;
      req_data[W-1:0] = d;
      req_decrypt[0] = m;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    step();
    step();
    rst = 1'b0;
    step();
    tbLastGrant = 1'b1;
    tbErrCnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    resp_ready = 2'b00;
    setJob(1'b0, rnd128(), rnd128(), 1'b1);
    setJob(1'b1, rnd128(), rnd128(), 1'b0);
    step();
    step();
    checks++;
    if ({req_ready, resp_valid, busy, core_start, core_decrypt, resp_err, err_count} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: ready=%b rvalid=%b busy=%b start=%b dec=%b err=%b errcnt=%0d required all 0",
               req_ready, resp_valid, busy, core_start, core_decrypt, resp_err, err_count);
    end
    checks++;
    if ({core_key, core_data, resp_data} !== {3*W{1'b0}}) begin
      errors++;
      $display("[TB] FAIL reset_data: key=%h data=%h resp=%h required 0", core_key, core_data, resp_data);
    end
    req_valid = 2'b00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int n, s0;
    setJob(1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    useFixed = 1;
    fixedResult = 128'h00112233445566778899aabbccddeeff;
    coreLat = 10;
    s0 = coreStarts;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_ready: actual=%b required=01", req_ready);
    end
    step();
    req_valid = 2'b00;
    checks++;
    if (core_start !== 1'b1 || core_key !== jobKey[0] || core_data !== jobData[0] || core_decrypt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_issue: start=%b key=%h data=%h dec=%b required 1/%h/%h/1",
               core_start, core_key, core_data, core_decrypt, jobKey[0], jobData[0]);
    end
    waitResp(200, n);
    checks++;
    if (n !== 11 || resp_valid !== 2'b01 || resp_data !== fixedResult || resp_err !== 1'b0 || coreStarts - s0 !== 1) begin
      errors++;
      $display("[TB] FAIL single_resp: latency=%0d rvalid=%b data=%h err=%b starts=%0d required 12/01/%h/0/1",
               n + 1, resp_valid, resp_data, resp_err, coreStarts - s0, fixedResult);
    end
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: rvalid=%b busy=%b required 00/0", resp_valid, busy);
    end
    useFixed = 0;
    tbLastGrant = 1'b0;
  endtask

  task automatic test_contention();
    logic [W-1:0] k, d;
    logic m, g;
    int n, w;
    doReset();
    setJob(1'b0, rnd128(), rnd128(), 1'b0);
    setJob(1'b1, rnd128(), rnd128(), 1'b1);
    resp_ready = 2'b11;
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      coreLat = $urandom_range(1, 8);
      g = ~tbLastGrant;
      w = 0;
      #1;
      while (req_ready == 2'b00 && w < 20) begin
        step();
        w++;
      end
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++;
        $display("[TB] FAIL contention_grant%0d: actual=%b required=%b", j, req_ready, onehot(g));
      end
      k = jobKey[g];
      d = jobData[g];
      m = jobDec[g];
      step();
      checks++;
      if (core_start !== 1'b1 || core_decrypt !== m || core_key !== k || core_data !== d) begin
        errors++;
        $display("[TB] FAIL contention_issue%0d: start=%b dec=%b key=%h required 1/%b/%h", j, core_start, core_decrypt, core_key, m, k);
      end
      setJob(g, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
      waitResp(100, n);
      checks++;
      if (resp_valid !== onehot(g) || resp_data !== coreFn(k, d, m) || resp_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL contention_resp%0d: rvalid=%b data=%h err=%b required %b/%h/0",
                 j, resp_valid, resp_data, resp_err, onehot(g), coreFn(k, d, m));
      end
      tbLastGrant = g;
    end
    step();
    req_valid = 2'b00;
    resp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] hold, exp0;
    int n, s0, bad;
    setJob(1'b1, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    coreLat = $urandom_range(1, 5);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bp_ready: actual=%b required=10", req_ready);
    end
    step();
    setJob(1'b0, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    exp0 = coreFn(jobKey[0], jobData[0], jobDec[0]);
    req_valid = 2'b01;
    s0 = coreStarts;
    waitResp(50, n);
    hold = resp_data;
    checks++;
    if (resp_valid !== 2'b10 || resp_data !== coreFn(cKey, cData, cDec) || cKey !== jobKey[1] && 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_resp: rvalid=%b data=%h required 10/%h", resp_valid, resp_data, coreFn(cKey, cData, cDec));
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c >= 10) resp_ready = 2'b01;
      step();
      checks++;
      if (resp_valid !== 2'b10 || resp_data !== hold || req_ready !== 2'b00 || coreStarts !== s0 || resp_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: rvalid=%b data=%h ready=%b starts=%0d required 10/%h/00/%0d",
                 c, resp_valid, resp_data, req_ready, coreStarts, hold, s0);
      end
    end
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b01;
    checks++;
    if (resp_valid !== 2'b00 || req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_next: rvalid=%b ready=%b required 00/01", resp_valid, req_ready);
    end
    step();
    req_valid = 2'b00;
    waitResp(50, n);
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== exp0) begin
      errors++;
      $display("[TB] FAIL bp_second: rvalid=%b data=%h required 01/%h", resp_valid, resp_data, exp0);
    end
    step();
    resp_ready = 2'b00;
    tbLastGrant = 1'b0;
  endtask

  task automatic test_timeout();
    logic [W-1:0] exp1;
    int n;
    coreLat = 0;
    setJob(1'b0, rnd128(), rnd128(), 1'b0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    waitResp(100, n);
    checks++;
    if (n !== 65 || resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_data !== '0 || err_count !== 8'(tbErrCnt + 1)) begin
      errors++;
      $display("[TB] FAIL timeout_resp: latency=%0d rvalid=%b err=%b data=%h errcnt=%0d required 66/01/1/0/%0d",
               n + 1, resp_valid, resp_err, resp_data, err_count, tbErrCnt + 1);
    end
    tbErrCnt++;
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    injectVal = rnd128();
    injectDone = 1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || resp_data !== '0 || err_count !== 8'(tbErrCnt)) begin
      errors++;
      $display("[TB] FAIL timeout_stale: busy=%b rvalid=%b data=%h errcnt=%0d required 0/00/0/%0d",
               busy, resp_valid, resp_data, err_count, tbErrCnt);
    end
    coreLat = $urandom_range(1, 20);
    setJob(1'b1, rnd128(), rnd128(), 1'b1);
    exp1 = coreFn(jobKey[1], jobData[1], 1'b1);
    req_valid = 2'b10;
    resp_ready = 2'b10;
    step();
    req_valid = 2'b00;
    waitResp(100, n);
    checks++;
    if (resp_valid !== 2'b10 || resp_err !== 1'b0 || resp_data !== exp1) begin
      errors++;
      $display("[TB] FAIL timeout_recover: rvalid=%b err=%b data=%h required 10/0/%h", resp_valid, resp_err, resp_data, exp1);
    end
    step();
    resp_ready = 2'b00;
    tbLastGrant = 1'b1;
  endtask

  task automatic test_edge();
    logic [W-1:0] exp0;
    int n;
    coreLat = 64;
    setJob(1'b0, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    exp0 = coreFn(jobKey[0], jobData[0], jobDec[0]);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    waitResp(100, n);
    checks++;
    if (n !== 65 || resp_valid !== 2'b01 || resp_err !== 1'b0 || resp_data !== exp0 || err_count !== 8'(tbErrCnt)) begin
      errors++;
      $display("[TB] FAIL edge_done63: latency=%0d rvalid=%b err=%b data=%h errcnt=%0d required 66/01/0/%h/%0d",
               n + 1, resp_valid, resp_err, resp_data, err_count, exp0, tbErrCnt);
    end
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    coreLat = 65;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    waitResp(100, n);
    step();
    step();
    checks++;
    if (n !== 65 || resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_data !== '0 || err_count !== 8'(tbErrCnt + 1)) begin
      errors++;
      $display("[TB] FAIL edge_late: latency=%0d rvalid=%b err=%b data=%h errcnt=%0d required 66/01/1/0/%0d",
               n + 1, resp_valid, resp_err, resp_data, err_count, tbErrCnt + 1);
    end
    tbErrCnt++;
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    tbLastGrant = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp0;
    int n, seen;
    coreLat = 30;
    setJob(1'b1, rnd128(), rnd128(), 1'b1);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    repeat (5) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_busy: actual=%b required=1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, busy, core_start, core_decrypt, resp_err, err_count, core_key, core_data, resp_data} !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_zero: rvalid=%b busy=%b start=%b dec=%b errcnt=%0d key=%h required all 0",
               resp_valid, busy, core_start, core_decrypt, err_count, core_key);
    end
    step();
    rst = 1'b0;
    tbLastGrant = 1'b1;
    tbErrCnt = 0;
    seen = 0;
    repeat (40) begin
      step();
      if (resp_valid !== 2'b00 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0 || err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_quiet: active_cycles=%0d errcnt=%0d required 0/0", seen, err_count);
    end
    coreLat = $urandom_range(1, 10);
    setJob(1'b0, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    setJob(1'b1, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    exp0 = coreFn(jobKey[0], jobData[0], jobDec[0]);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== onehot(~tbLastGrant)) begin
      errors++;
      $display("[TB] FAIL rstmid_tie: actual=%b required=%b", req_ready, onehot(~tbLastGrant));
    end
    step();
    req_valid = 2'b00;
    resp_ready = 2'b01;
    waitResp(100, n);
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== exp0) begin
      errors++;
      $display("[TB] FAIL rstmid_job: rvalid=%b data=%h required 01/%h", resp_valid, resp_data, exp0);
    end
    step();
    resp_ready = 2'b00;
    tbLastGrant = 1'b0;
  endtask

  task automatic test_saturation();
    int n, missing;
    missing = 0;
    coreLat = 0;
    for (int i = 0; i < 260; i++) begin
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      waitResp(100, n);
      if (resp_err !== 1'b1 || resp_valid !== 2'b01) missing++;
      tbErrCnt = (tbErrCnt < 255) ? tbErrCnt + 1 : 255;
      resp_ready = 2'b01;
      step();
      resp_ready = 2'b00;
    end
    checks++;
    if (missing !== 0 || err_count !== 8'(tbErrCnt)) begin
      errors++;
      $display("[TB] FAIL saturation: errcnt=%0d bad_responses=%0d required %0d/0", err_count, missing, tbErrCnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    req_key = '0;
    req_data = '0;
    req_decrypt = 2'b00;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_edge();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
